// File: rtl/change_dispense_ctrl.sv
// rtl/change_dispense_ctrl.sv - greedy 5/2/1 coin-change dispenser with hopper handshakes
// Optional hopper timeout fault is enabled by defining CHANGE_TIMEOUT_EN.
module change_dispense_ctrl #(
  parameter int TIMEOUT_CYC = 255,
  parameter int INV_INIT    = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [3:0] req_amt,
  output logic       req_ready,
  input  logic       refill,
  output logic       hop_05,
  output logic       hop_02,
  output logic       hop_01,
  input  logic       sens_05,
  input  logic       sens_02,
  input  logic       sens_01,
  output logic       done,
  output logic       short,
  output logic [3:0] remain,
  output logic       fault
);

  if (INV_INIT < 0 || INV_INIT > 15) begin : g_bad_inv_init
    $error("INV_INIT must be within 0..15");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be within 1..255");
  end

  localparam logic [3:0] INV_RST = 4'(INV_INIT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PICK  = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t     r_state;
  logic [3:0] r_rem;
  logic [3:0] r_inv_05;
  logic [3:0] r_inv_02;
  logic [3:0] r_inv_01;
  // One-hot selected denomination: bit 2 = 5, bit 1 = 2, bit 0 = 1.
  logic [2:0] r_sel;

`ifdef CHANGE_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] r_cnt;
`endif

  logic [2:0] w_pick;
  logic       w_hit;
  logic [3:0] w_coin;

  always_comb begin
    w_pick = 3'b000;
    if (r_rem >= 4'd5 && r_inv_05 != 4'd0)
      w_pick = 3'b100;
    else if (r_rem >= 4'd2 && r_inv_02 != 4'd0)
      w_pick = 3'b010;
    else if (r_rem != 4'd0 && r_inv_01 != 4'd0)
      w_pick = 3'b001;
  end

  assign w_hit  = (r_sel[2] & sens_05) | (r_sel[1] & sens_02) | (r_sel[0] & sens_01);
  assign w_coin = r_sel[2] ? 4'd5 : (r_sel[1] ? 4'd2 : 4'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_rem    <= 4'd0;
      r_inv_05 <= INV_RST;
      r_inv_02 <= INV_RST;
      r_inv_01 <= INV_RST;
      r_sel    <= 3'b000;
`ifdef CHANGE_TIMEOUT_EN
      r_cnt    <= 8'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (refill) begin
            r_inv_05 <= INV_RST;
            r_inv_02 <= INV_RST;
            r_inv_01 <= INV_RST;
          end
          if (req_valid) begin
            r_rem   <= req_amt;
            r_state <= S_PICK;
          end
        end
        S_PICK: begin
          if (w_pick == 3'b000) begin
            r_state <= S_DONE;
          end else begin
            r_sel   <= w_pick;
            r_state <= S_WAIT;
`ifdef CHANGE_TIMEOUT_EN
            r_cnt   <= 8'd0;
`endif
          end
        end
        S_WAIT: begin
          // A matching sensor takes priority over a timeout expiring on the same edge.
          if (w_hit) begin
            r_rem   <= r_rem - w_coin;
            r_state <= S_PICK;
            if (r_sel[2] && r_inv_05 != 4'd0) r_inv_05 <= r_inv_05 - 4'd1;
            if (r_sel[1] && r_inv_02 != 4'd0) r_inv_02 <= r_inv_02 - 4'd1;
            if (r_sel[0] && r_inv_01 != 4'd0) r_inv_01 <= r_inv_01 - 4'd1;
          end
`ifdef CHANGE_TIMEOUT_EN
          else if (r_cnt == TO_LAST) begin
            r_state <= S_FAULT;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
`endif
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        S_FAULT: begin
          if (refill) begin
            r_inv_05 <= INV_RST;
            r_inv_02 <= INV_RST;
            r_inv_01 <= INV_RST;
            r_state  <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign hop_05    = (r_state == S_WAIT) & r_sel[2];
  assign hop_02    = (r_state == S_WAIT) & r_sel[1];
  assign hop_01    = (r_state == S_WAIT) & r_sel[0];
  assign done      = (r_state == S_DONE);
  assign short     = (r_state == S_DONE) & (r_rem != 4'd0);
  assign remain    = (r_state == S_DONE) ? r_rem : 4'd0;

`ifdef CHANGE_TIMEOUT_EN
  assign fault = (r_state == S_FAULT);
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// tb/tb_change_dispense_ctrl.sv - directed self-checking bench for change_dispense_ctrl
// Timeout scenario depends on CHANGE_TIMEOUT_EN being defined for both bench and RTL.
module tb_change_dispense_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic [3:0] req_amt = 4'd0;
  logic       req_ready;
  logic       refill = 1'b0;
  logic       hop_05, hop_02, hop_01;
  logic       sens_05 = 1'b0, sens_02 = 1'b0, sens_01 = 1'b0;
  logic       done, short, fault;
  logic [3:0] remain;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] seq;
  int          ncoin;
  logic        got_done;
  logic        sh;
  logic [3:0]  rm;

  change_dispense_ctrl #(.TIMEOUT_CYC(4), .INV_INIT(15)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_amt(req_amt), .req_ready(req_ready),
    .refill(refill), .hop_05(hop_05), .hop_02(hop_02), .hop_01(hop_01),
    .sens_05(sens_05), .sens_02(sens_02), .sens_01(sens_01),
    .done(done), .short(short), .remain(remain), .fault(fault)
  );

  always #5 clk = ~clk;

  // Issues one request, answers every hopper command with its sensor, records coin order.
  task automatic run_req(input logic [3:0] amt, input logic with_refill);
    seq = 64'd0; ncoin = 0; got_done = 1'b0; sh = 1'b0; rm = 4'd0;
    @(negedge clk);
    req_valid = 1'b1; req_amt = amt; refill = with_refill;
    @(posedge clk); #1;
    req_valid = 1'b0; refill = 1'b0;
    for (int i = 0; i < 200 && !got_done; i++) begin
      @(negedge clk);
      if (done) begin
        got_done = 1'b1; sh = short; rm = remain;
      end else if (hop_05 | hop_02 | hop_01) begin
        n_checks++;
        if ((32'(hop_05) + 32'(hop_02) + 32'(hop_01)) != 1) begin
          n_fail++;
          $display("FAIL hop_onehot: got %b%b%b required one-hot", hop_05, hop_02, hop_01);
        end
        seq = {seq[59:0], hop_05 ? 4'h5 : (hop_02 ? 4'h2 : 4'h1)};
        ncoin++;
        sens_05 = hop_05; sens_02 = hop_02; sens_01 = hop_01;
        @(posedge clk); #1;
        sens_05 = 1'b0; sens_02 = 1'b0; sens_01 = 1'b0;
      end
    end
    n_checks++;
    if (!got_done) begin
      n_fail++;
      $display("FAIL req_done_timeout: amt %0d got no done, required done within 200 cycles", amt);
    end
  endtask

  task automatic do_refill();
    @(negedge clk); refill = 1'b1;
    @(posedge clk); #1; refill = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({hop_05, hop_02, hop_01, done, short, remain, fault} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 0", {hop_05, hop_02, hop_01, done, short, remain, fault});
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b required 1", req_ready);
    end
  endtask

  task automatic test_greedy_basic();
    run_req(4'd8, 1'b0);
    n_checks++;
    if (seq !== 64'h521) begin n_fail++; $display("FAIL amt8_order: got %0h required 521", seq); end
    n_checks++;
    if (sh !== 1'b0 || rm !== 4'd0) begin
      n_fail++; $display("FAIL amt8_short: got short=%b remain=%0d required 0/0", sh, rm);
    end
  endtask

  task automatic test_zero_amt();
    logic any_hop;
    @(negedge clk); req_valid = 1'b1; req_amt = 4'd0;
    @(posedge clk); #1; req_valid = 1'b0;
    any_hop = hop_05 | hop_02 | hop_01;
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL amt0_early: got done=%b required 0", done); end
    @(posedge clk); #1;
    any_hop = any_hop | hop_05 | hop_02 | hop_01;
    n_checks++;
    if (done !== 1'b1 || short !== 1'b0 || remain !== 4'd0) begin
      n_fail++; $display("FAIL amt0_done: got done=%b short=%b remain=%0d required 1/0/0", done, short, remain);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || req_ready !== 1'b1 || any_hop !== 1'b0) begin
      n_fail++; $display("FAIL amt0_after: got done=%b ready=%b hop=%b required 0/1/0", done, req_ready, any_hop);
    end
  endtask

  task automatic test_depletion();
    do_refill();
    for (int k = 0; k < 15; k++) begin
      run_req(4'd5, 1'b0);
      n_checks++;
      if (seq !== 64'h5) begin n_fail++; $display("FAIL drain05_%0d: got %0h required 5", k, seq); end
    end
    // inv_05 now 0: 9 must come out as 2,2,2,2,1.
    run_req(4'd9, 1'b0);
    n_checks++;
    if (seq !== 64'h22221 || sh !== 1'b0) begin
      n_fail++; $display("FAIL amt9_no5: got %0h short=%b required 22221/0", seq, sh);
    end
    // inv_02=11: 15 takes seven 2s and one 1.
    run_req(4'd15, 1'b0);
    n_checks++;
    if (seq !== 64'h22222221 || sh !== 1'b0) begin
      n_fail++; $display("FAIL amt15: got %0h short=%b required 22222221/0", seq, sh);
    end
    run_req(4'd8, 1'b0);
    n_checks++;
    if (seq !== 64'h2222) begin n_fail++; $display("FAIL amt8_last2s: got %0h required 2222", seq); end
    // inv_02=0, inv_01=13: twelve 1s leaves exactly one.
    run_req(4'd12, 1'b0);
    n_checks++;
    if (ncoin !== 12 || seq[3:0] !== 4'h1 || sh !== 1'b0) begin
      n_fail++; $display("FAIL amt12_ones: got %0d coins last %0h short=%b required 12/1/0", ncoin, seq[3:0], sh);
    end
    run_req(4'd4, 1'b0);
    n_checks++;
    if (seq !== 64'h1 || sh !== 1'b1 || rm !== 4'd3) begin
      n_fail++; $display("FAIL amt4_short: got %0h short=%b remain=%0d required 1/1/3", seq, sh, rm);
    end
    run_req(4'd3, 1'b0);
    n_checks++;
    if (ncoin !== 0 || sh !== 1'b1 || rm !== 4'd3) begin
      n_fail++; $display("FAIL amt3_empty: got %0d coins short=%b remain=%0d required 0/1/3", ncoin, sh, rm);
    end
  endtask

  task automatic test_refill_with_accept();
    run_req(4'd5, 1'b1);
    n_checks++;
    if (seq !== 64'h5 || sh !== 1'b0) begin
      n_fail++; $display("FAIL refill_accept: got %0h short=%b required 5/0", seq, sh);
    end
  endtask

  task automatic test_reset_in_wait();
    logic seen;
    seen = 1'b0;
    @(negedge clk); req_valid = 1'b1; req_amt = 4'd7;
    @(posedge clk); #1; req_valid = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = hop_05;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL rstwait_hop: got hop_05=0 required 1"); end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (hop_05 !== 1'b0) begin n_fail++; $display("FAIL rstwait_drop: got hop_05=%b required 0", hop_05); end
    @(negedge clk); rst = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rstwait_ready: got %b required 1", req_ready); end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen = seen | done | hop_05 | hop_02 | hop_01;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL rstwait_nodone: got activity=%b required 0", seen); end
    run_req(4'd15, 1'b0);
    n_checks++;
    if (seq !== 64'h555 || sh !== 1'b0) begin
      n_fail++; $display("FAIL rstwait_inv: got %0h short=%b required 555/0", seq, sh);
    end
  endtask

  task automatic test_timeout();
    int nhigh;
    nhigh = 0;
    @(negedge clk); req_valid = 1'b1; req_amt = 4'd5;
    @(posedge clk); #1; req_valid = 1'b0;
`ifdef CHANGE_TIMEOUT_EN
    for (int i = 0; i < 50 && !fault; i++) begin
      @(negedge clk);
      if (hop_05 && !fault) nhigh++;
    end
    n_checks++;
    if (nhigh !== 4) begin n_fail++; $display("FAIL timeout_len: got %0d cycles required 4", nhigh); end
    n_checks++;
    if (fault !== 1'b1 || hop_05 !== 1'b0 || req_ready !== 1'b0) begin
      n_fail++; $display("FAIL timeout_fault: got fault=%b hop=%b ready=%b required 1/0/0", fault, hop_05, req_ready);
    end
    do_refill();
    n_checks++;
    if (fault !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL timeout_refill: got fault=%b ready=%b required 0/1", fault, req_ready);
    end
`else
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (hop_05 && !fault) nhigh++;
    end
    n_checks++;
    if (nhigh < 298 || fault !== 1'b0 || hop_05 !== 1'b1) begin
      n_fail++; $display("FAIL notimeout_wait: got %0d high fault=%b required >=298/0", nhigh, fault);
    end
    sens_05 = 1'b1;
    @(posedge clk); #1; sens_05 = 1'b0;
    got_done = 1'b0;
    for (int i = 0; i < 10 && !got_done; i++) begin
      @(negedge clk);
      got_done = done;
    end
    n_checks++;
    if (!got_done) begin n_fail++; $display("FAIL notimeout_done: got no done required done"); end
    @(negedge clk);
`endif
    run_req(4'd15, 1'b0);
    n_checks++;
    if (seq !== 64'h555) begin n_fail++; $display("FAIL after_timeout: got %0h required 555", seq); end
  endtask

  initial begin
    test_reset();
    test_greedy_basic();
    test_zero_amt();
    test_depletion();
    test_refill_with_accept();
    test_reset_in_wait();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
